// File: rtl/progmem_pkg.sv
// progmem_pkg: shared types for the program-memory fetch path.
// Bus widths, fetch FSM states, response codes and FIFO entry layout.
package progmem_pkg;

  localparam int PM_AW = 12;
  localparam int PM_DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    GAP
  } fetch_state_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_RSVD   = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } pm_resp_t;

  typedef struct packed {
    logic [PM_AW-1:0] addr;
    logic [PM_DW-1:0] data;
  } fetch_ent_t;

endpackage

// File: rtl/progmem_fetch_buffer_fifo.sv
// fetch_fifo: register FIFO of {addr, data} prefetch entries.
// Clear wins over push/pop; head is the oldest entry.
module fetch_fifo
  import progmem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [$bits(fetch_ent_t)-1:0] push_data,
  input  logic                          pop,
  input  logic                          clear,
  output logic [$bits(fetch_ent_t)-1:0] head,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = $bits(fetch_ent_t);

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;

  // Next pointers, count and storage from push/pop/clear
  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clear) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_data;
        wr_d = wr_q + 1'b1;
      end
      if (pop) rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + {{AW{1'b0}}, push}
                    - {{AW{1'b0}}, pop};
    end
  end

  // Pointer and count state
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage, no reset needed
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/progmem_fetch_buffer.sv
// progmem_fetch_buffer: CPU fetch port to program-ROM prefetcher.
// Sequential hits come from the FIFO; jumps flush and refetch.
module progmem_fetch_buffer
  import progmem_pkg::*;
#(
  parameter int               DEPTH      = 4,
  parameter logic [PM_AW-1:0] RESET_ADDR = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [11:0] cpu_addr,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  output logic [11:0] pm_address,
  output logic        pm_read,
  input  logic [31:0] pm_readdata,
  input  logic [1:0]  pm_response,
  input  logic        pm_waitrequest,
  output logic        pm_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t     state_q, state_d;
  logic [PM_AW-1:0] pm_address_q, pm_address_d;
  logic [PM_AW-1:0] fetch_ptr_q, fetch_ptr_d;
  logic             pm_read_q, pm_read_d;
  logic             pm_err_q, pm_err_d;
  logic             drop_q, drop_d;

  logic             push, hit, pending, miss;
  logic             accept, full;
  logic [CW-1:0]    count;
  logic [$bits(fetch_ent_t)-1:0] head_raw;
  fetch_ent_t       head, push_ent;

  assign head     = fetch_ent_t'(head_raw);
  assign push_ent = '{addr: pm_address_q, data: pm_readdata};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_ent),
    .pop       (hit),
    .clear     (miss),
    .head      (head_raw),
    .count     (count)
  );

  assign full    = count == CW'(DEPTH);
  assign hit     = cpu_req && count != '0
                && head.addr == cpu_addr;
  assign pending = cpu_req && count == '0
                && state_q == READ && !drop_q
                && pm_address_q == cpu_addr;
  assign miss    = cpu_req && !hit && !pending;
  assign accept  = state_q == READ && !pm_waitrequest;

  assign cpu_ack    = hit;
  assign cpu_rdata  = head.data;
  assign pm_address = pm_address_q;
  assign pm_read    = pm_read_q;
  assign pm_err     = pm_err_q;

  // Bus FSM: issue, complete or drop reads; redirect on a miss
  always_comb begin
    state_d      = state_q;
    pm_address_d = pm_address_q;
    pm_read_d    = pm_read_q;
    pm_err_d     = pm_err_q;
    drop_d       = drop_q;
    fetch_ptr_d  = fetch_ptr_q;
    push         = 1'b0;
    if (accept && pm_response != RESP_OKAY)
      pm_err_d = 1'b1;
    unique case (state_q)
      IDLE, GAP: begin
        if (miss) begin
          pm_address_d = cpu_addr;
          pm_read_d    = 1'b1;
          state_d      = READ;
        end else if (!full) begin
          pm_address_d = fetch_ptr_q;
          pm_read_d    = 1'b1;
          state_d      = READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (accept) begin
          pm_read_d = 1'b0;
          state_d   = GAP;
          drop_d    = 1'b0;
          if (!drop_q && !miss) begin
            push        = 1'b1;
            fetch_ptr_d = pm_address_q + 1'b1;
          end
        end else if (miss) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (miss) fetch_ptr_d = cpu_addr;
  end

  // Registered FSM state and bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pm_address_q <= RESET_ADDR;
      pm_read_q    <= 1'b0;
      pm_err_q     <= 1'b0;
      drop_q       <= 1'b0;
      fetch_ptr_q  <= RESET_ADDR;
    end else begin
      state_q      <= state_d;
      pm_address_q <= pm_address_d;
      pm_read_q    <= pm_read_d;
      pm_err_q     <= pm_err_d;
      drop_q       <= drop_d;
      fetch_ptr_q  <= fetch_ptr_d;
    end
  end

endmodule

// File: tb/tb_progmem_fetch_buffer.sv
// tb_progmem_fetch_buffer: table, directed and random checks
// against a ROM/slave model and sticky-error reference.
module tb_progmem_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [11:0] cpu_addr;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic [11:0] pm_address;
  logic        pm_read;
  logic [31:0] pm_readdata;
  logic [1:0]  pm_response;
  logic        pm_waitrequest;
  logic        pm_err;

  int checks = 0;
  int failures = 0;

  int          wait_len = 1;
  int          wcnt = 0;
  logic        err_en = 1'b0;
  logic [11:0] err_addr = 12'h000;
  logic        mon_en = 1'b0;
  logic        err_m = 1'b0;
  logic        acc_q = 1'b0;
  logic        hold_q = 1'b0;
  logic [11:0] addr_q = 12'h000;
  logic [11:0] acc_log[$];

  typedef struct {
    logic        req;
    logic [11:0] addr;
    logic        ack;
    logic        rd;
    logic [11:0] pa;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  progmem_fetch_buffer #(.DEPTH(4), .RESET_ADDR(12'h000)) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_req        (cpu_req),
    .cpu_addr       (cpu_addr),
    .cpu_ack        (cpu_ack),
    .cpu_rdata      (cpu_rdata),
    .pm_address     (pm_address),
    .pm_read        (pm_read),
    .pm_readdata    (pm_readdata),
    .pm_response    (pm_response),
    .pm_waitrequest (pm_waitrequest),
    .pm_err         (pm_err)
  );

  function automatic logic [31:0] rom(input logic [11:0] a);
    return {4'hC, a, 4'h5, ~a};
  endfunction

  assign pm_readdata    = rom(pm_address);
  assign pm_waitrequest = pm_read && (wcnt < wait_len);
  assign pm_response    = (err_en && pm_address == err_addr)
                        ? 2'b10 : 2'b00;

  always @(posedge clk) begin
    wcnt   <= pm_read ? wcnt + 1 : 0;
    acc_q  <= !rst && pm_read && !pm_waitrequest;
    hold_q <= !rst && pm_read && pm_waitrequest;
    addr_q <= pm_address;
    if (rst) err_m <= 1'b0;
    else if (pm_read && !pm_waitrequest && pm_response != 2'b00)
      err_m <= 1'b1;
    if (!rst && pm_read && !pm_waitrequest)
      acc_log.push_back(pm_address);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("pm_err_model", {31'b0, pm_err}, {31'b0, err_m});
      if (hold_q) begin
        chk("hold_read", {31'b0, pm_read}, 32'd1);
        chk("hold_addr", {20'b0, pm_address}, {20'b0, addr_q});
      end
      if (acc_q) chk("gap_after_read", {31'b0, pm_read}, 32'd0);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    cpu_req = 1'b0;
    cpu_addr = 12'h000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    acc_log.delete();
  endtask

  task automatic fetch(input logic [11:0] a, input int lat,
                       input string nm);
    int n;
    n = 0;
    cpu_req = 1'b1;
    cpu_addr = a;
    #1;
    while (!cpu_ack && n < 60) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!cpu_ack) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: no ack for addr %h", nm, a);
    end else begin
      chk({nm, "_rdata"}, cpu_rdata, rom(a));
      if (lat >= 0) chk({nm, "_lat"}, n, lat);
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
  endtask

  function automatic vec_t mk(logic r, logic [11:0] a, logic k,
                              logic p, logic [11:0] pa);
    vec_t v;
    v.req = r; v.addr = a; v.ack = k; v.rd = p; v.pa = pa;
    return v;
  endfunction

  initial begin
    logic [11:0] a;
    int k;

    tbl.push_back(mk(0, 0, 0, 0, 12'h000));
    tbl.push_back(mk(0, 0, 0, 1, 12'h000));
    tbl.push_back(mk(0, 0, 0, 1, 12'h000));
    tbl.push_back(mk(0, 0, 0, 0, 12'h000));
    tbl.push_back(mk(0, 0, 0, 1, 12'h001));
    tbl.push_back(mk(0, 0, 0, 1, 12'h001));
    tbl.push_back(mk(0, 0, 0, 0, 12'h001));
    tbl.push_back(mk(0, 0, 0, 1, 12'h002));
    tbl.push_back(mk(0, 0, 0, 1, 12'h002));
    tbl.push_back(mk(0, 0, 0, 0, 12'h002));
    tbl.push_back(mk(0, 0, 0, 1, 12'h003));
    tbl.push_back(mk(0, 0, 0, 1, 12'h003));
    for (int i = 12; i < 16; i++)
      tbl.push_back(mk(0, 0, 0, 0, 12'h003));
    tbl.push_back(mk(1, 12'h000, 1, 0, 12'h003));
    tbl.push_back(mk(1, 12'h001, 1, 0, 12'h003));
    tbl.push_back(mk(1, 12'h002, 1, 1, 12'h004));
    tbl.push_back(mk(1, 12'h003, 1, 1, 12'h004));
    tbl.push_back(mk(1, 12'h004, 1, 0, 12'h004));

    do_reset();
    mon_en = 1'b1;
    chk("reset_pm_err", {31'b0, pm_err}, 32'd0);
    foreach (tbl[i]) begin
      cpu_req = tbl[i].req;
      cpu_addr = tbl[i].addr;
      #1;
      chk($sformatf("t%0d_ack", i), {31'b0, cpu_ack},
          {31'b0, tbl[i].ack});
      if (tbl[i].ack)
        chk($sformatf("t%0d_rdata", i), cpu_rdata,
            rom(tbl[i].addr));
      chk($sformatf("t%0d_pm_read", i), {31'b0, pm_read},
          {31'b0, tbl[i].rd});
      chk($sformatf("t%0d_pm_addr", i), {20'b0, pm_address},
          {20'b0, tbl[i].pa});
      @(posedge clk);
      #1;
    end
    cpu_req = 1'b0;

    chk("jump_outstanding_rd", {31'b0, pm_read}, 32'd1);
    chk("jump_outstanding_addr", {20'b0, pm_address}, 32'h005);
    fetch(12'h100, 5, "jump");
    chk("jump_log_len", acc_log.size(), 7);
    if (acc_log.size() >= 7) begin
      chk("jump_log5", {20'b0, acc_log[5]}, 32'h005);
      chk("jump_log6", {20'b0, acc_log[6]}, 32'h100);
    end

    do_reset();
    fetch(12'hFFE, 3, "wrap0");
    fetch(12'hFFF, -1, "wrap1");
    fetch(12'h000, -1, "wrap2");
    fetch(12'h001, -1, "wrap3");
    chk("wrap_log_len", acc_log.size() >= 4, 1);
    if (acc_log.size() >= 4) begin
      chk("wrap_log0", {20'b0, acc_log[0]}, 32'hFFE);
      chk("wrap_log1", {20'b0, acc_log[1]}, 32'hFFF);
      chk("wrap_log2", {20'b0, acc_log[2]}, 32'h000);
      chk("wrap_log3", {20'b0, acc_log[3]}, 32'h001);
    end

    do_reset();
    err_en = 1'b1;
    err_addr = 12'h002;
    fetch(12'h000, 3, "err0");
    fetch(12'h001, -1, "err1");
    chk("err_before", {31'b0, pm_err}, 32'd0);
    fetch(12'h002, -1, "err2");
    chk("err_set", {31'b0, pm_err}, 32'd1);
    fetch(12'h003, -1, "err3");
    repeat (10) @(posedge clk);
    #1;
    chk("err_sticky", {31'b0, pm_err}, 32'd1);
    err_en = 1'b0;
    do_reset();
    chk("err_cleared", {31'b0, pm_err}, 32'd0);

    wait_len = 5;
    @(posedge clk);
    #1;
    chk("rst_mid_rd", {31'b0, pm_read}, 32'd1);
    chk("rst_mid_wait", {31'b0, pm_waitrequest}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_rd_drop", {31'b0, pm_read}, 32'd0);
    chk("rst_addr", {20'b0, pm_address}, 32'h000);
    cpu_req = 1'b1;
    cpu_addr = 12'h000;
    #1;
    chk("rst_empty_ack", {31'b0, cpu_ack}, 32'd0);
    cpu_req = 1'b0;
    wait_len = 1;
    @(posedge clk);
    #1;
    chk("rst_first_rd", {31'b0, pm_read}, 32'd1);
    chk("rst_first_addr", {20'b0, pm_address}, 32'h000);

    do_reset();
    err_en = 1'b1;
    err_addr = 12'($urandom_range(0, 4095));
    a = 12'($urandom_range(0, 4095));
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) < 7) a = a + 12'd1;
      else if ($urandom_range(0, 3) == 0) a = 12'hFFD;
      else a = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 9) == 0) err_addr = a;
      wait_len = $urandom_range(1, 3);
      fetch(a, -1, "rnd");
      k = $urandom_range(0, 3);
      repeat (k) @(posedge clk);
      #1;
    end
    chk("rnd_err_final", {31'b0, pm_err}, {31'b0, err_m});
    err_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
